sequencer_scheduler: RTL and testbench
======================================

SEQUENCER_SCHEDULER -- requirements
Module: sequencer_scheduler

Interface
REQ-001 Parameter PERIOD_DEFAULT, 5000, beat period in clk cycles after reset (2 beats/s at 10 kHz).
REQ-002 Parameter PERIOD_MIN, 1000, smallest allowed beat period.
REQ-003 Parameter PERIOD_MAX, 10000, largest allowed beat period.
REQ-004 Parameter PERIOD_STEP, 500, period change per tempo pulse.
REQ-005 clk  input  1  system clock, 10 kHz.
REQ-006 n_rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-007 sequencer_on  input  1  1 = sequencer mode, 0 = piano mode.
REQ-008 play_pause  input  1  edge-detected single-cycle pulse; toggles run/stop.
REQ-009 tempo_up  input  1  edge-detected pulse; shortens the beat period.
REQ-010 tempo_down  input  1  edge-detected pulse; lengthens the beat period.
REQ-011 step_next  input  1  edge-detected pulse; advances the edit-step selection.
REQ-012 toggle_in  input  1  edge-detected pulse; note-cycle request for the selected step.
REQ-013 notes_in  input  32  note codes of the 8 step players; step k at bits [4k+3:4k].
REQ-014 beat  output  4  current beat, 0-7; bit 3 always 0.
REQ-015 beat_strobe  output  1  one-cycle pulse on every beat advance.
REQ-016 sel_step  output  3  step currently selected for editing.
REQ-017 toggle_out  output  8  one-hot toggle routed to step player sel_step.
REQ-018 note_out  output  4  note code for the audio path; 0 = silence.
REQ-019 running  output  1  1 when in RUNNING.

Function
REQ-020 The FSM SHALL have states IDLE, STOPPED and RUNNING.
REQ-021 Any state with sequencer_on=0 SHALL go to IDLE on the next edge, taking priority over all pulses.
REQ-022 IDLE with sequencer_on=1 SHALL go to STOPPED.
REQ-023 STOPPED with a play_pause pulse SHALL go to RUNNING; RUNNING with a play_pause pulse SHALL go to STOPPED.
REQ-024 A 16-bit tick counter SHALL count 0..period-1 only in RUNNING.
- Counter holds its value in STOPPED.
- Counter clears to 0 in IDLE.
REQ-025 In RUNNING, when tick >= period-1:
- tick SHALL go to 0.
- beat SHALL increment, wrapping 7->0.
- beat_strobe SHALL be 1 for exactly that following cycle.
REQ-026 beat SHALL hold in STOPPED and clear to 0 in IDLE.
REQ-027 A tempo_up pulse SHALL set period = max(period-PERIOD_STEP, PERIOD_MIN).
REQ-028 A tempo_down pulse SHALL set period = min(period+PERIOD_STEP, PERIOD_MAX).
REQ-029 Simultaneous tempo_up and tempo_down SHALL leave period unchanged.
REQ-030 Tempo pulses SHALL be ignored in IDLE.
REQ-031 A period change SHALL take effect the next cycle without clearing tick.
- If tick is already >= new period-1, the beat SHALL advance on the next RUNNING cycle.
REQ-032 A step_next pulse SHALL increment sel_step, wrapping 7->0.
- Honoured in STOPPED and RUNNING; ignored in IDLE.
REQ-033 sel_step SHALL clear to 0 in IDLE.
REQ-034 toggle_out SHALL be registered: a toggle_in pulse in cycle N SHALL give toggle_out = 1<<sel_step(N) in cycle N+1 only, and 0 otherwise.
REQ-035 If toggle_in and step_next arrive in the same cycle, the toggle SHALL go to the pre-increment step.
REQ-036 toggle_in SHALL be ignored in IDLE.
REQ-037 note_out SHALL be registered with 1-cycle latency.
- In RUNNING: note_out = notes_in slice for the beat value of the previous cycle.
- In STOPPED: note_out = notes_in slice for sel_step (edit preview).
- In IDLE: note_out = 0.
REQ-038 running SHALL equal (state == RUNNING).

Reset
REQ-039 With n_rst=0 at a rising edge, all of the following SHALL be set:
- state = IDLE
- tick = 0
- period = PERIOD_DEFAULT
- beat = 0
- beat_strobe = 0
- sel_step = 0
- toggle_out = 0
- note_out = 0
- running = 0
REQ-040 Reset mid-beat SHALL discard the partial tick count and any pending toggle.
REQ-041 Reset SHALL NOT act asynchronously: an n_rst pulse not spanning a rising edge has no effect.

Verification (bench parameters PERIOD_DEFAULT=4, PERIOD_MIN=2, PERIOD_MAX=6, PERIOD_STEP=1)
REQ-042 Reset, sequencer_on=1, play_pause pulse, run 40 cycles -> beat_strobe every 4 cycles; beat 0..7 then 0; one-cycle strobes only.
REQ-043 Running, tempo_up x3 -> period saturates at 2 (strobe every 2 cycles); tempo_down x5 -> saturates at 6; simultaneous up+down -> period unchanged.
REQ-044 STOPPED, step_next x9 -> sel_step = 1; toggle_in -> toggle_out = 8'b0000_0010 for one cycle; toggle_in+step_next together at sel_step=7 -> toggle_out = 8'b1000_0000, sel_step = 0.
REQ-045 notes_in = 32'hDCBA_9871, running -> note_out follows 1,7,8,9,A,B,C,D one cycle behind beat; play_pause -> beat frozen, note_out = slice at sel_step.
REQ-046 sequencer_on dropped mid-beat (beat=5, tick=2) -> next cycle IDLE: beat=0, note_out=0, sel_step=0; period retained.
REQ-047 n_rst held low one edge at beat=3 with period=6 -> all outputs 0, period=4; n_rst glitch between edges -> no change.

Source files
------------

// File: rtl/sequencer_scheduler.sv
// Beat sequencer: run/stop FSM, tempo-controlled beat counter, edit-step selection
// and routing of note codes / toggle pulses to the eight step players.
module sequencer_scheduler #(
   parameter int PERIOD_DEFAULT = 5000,
   parameter int PERIOD_MIN     = 1000,
   parameter int PERIOD_MAX     = 10000,
   parameter int PERIOD_STEP    = 500
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        sequencer_on,
   input  logic        play_pause,
   input  logic        tempo_up,
   input  logic        tempo_down,
   input  logic        step_next,
   input  logic        toggle_in,
   input  logic [31:0] notes_in,
   output logic [3:0]  beat,
   output logic        beat_strobe,
   output logic [2:0]  sel_step,
   output logic [7:0]  toggle_out,
   output logic [3:0]  note_out,
   output logic        running
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STOPPED = 2'd1,
      RUNNING = 2'd2
   } state_t;

   localparam logic [15:0] P_DEF  = 16'(PERIOD_DEFAULT);
   localparam logic [15:0] P_MIN  = 16'(PERIOD_MIN);
   localparam logic [15:0] P_MAX  = 16'(PERIOD_MAX);
   localparam logic [15:0] P_STEP = 16'(PERIOD_STEP);

   state_t      state_q, state_d;
   logic [15:0] tick_q, tick_d;
   logic [15:0] period_q, period_d;
   logic [15:0] tempo_next;
   logic [2:0]  beat_q, beat_d;
   logic        strobe_q, strobe_d;
   logic [2:0]  sel_q, sel_d;
   logic [7:0]  toggle_q, toggle_d;
   logic [3:0]  note_q, note_d;

   // Saturating tempo adjust; opposing pulses in the same cycle cancel out.
   always_comb begin
      tempo_next = period_q;
      if (tempo_up && !tempo_down) begin
         tempo_next = (period_q < P_MIN + P_STEP) ? P_MIN : period_q - P_STEP;
      end else if (tempo_down && !tempo_up) begin
         tempo_next = (period_q + P_STEP > P_MAX) ? P_MAX : period_q + P_STEP;
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      period_d = period_q;
      beat_d   = beat_q;
      strobe_d = 1'b0;
      sel_d    = sel_q;
      toggle_d = 8'h00;
      note_d   = note_q;
      // Dropping out of sequencer mode overrides every pulse; period survives.
      if (!sequencer_on) begin
         state_d = IDLE;
         tick_d  = 16'd0;
         beat_d  = 3'd0;
         sel_d   = 3'd0;
         note_d  = 4'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = STOPPED;
               tick_d  = 16'd0;
               beat_d  = 3'd0;
               sel_d   = 3'd0;
               note_d  = 4'd0;
            end
            STOPPED, RUNNING: begin
               period_d = tempo_next;
               if (step_next) sel_d = sel_q + 3'd1;
               if (toggle_in) toggle_d = 8'b1 << sel_q;
               if (play_pause) state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
               // The >= compare lets a shortened period fire at once if tick already passed it.
               if (state_q == RUNNING) begin
                  note_d = notes_in[{beat_q, 2'b00} +: 4];
                  if (tick_q >= period_q - 16'd1) begin
                     tick_d   = 16'd0;
                     beat_d   = beat_q + 3'd1;
                     strobe_d = 1'b1;
                  end else begin
                     tick_d = tick_q + 16'd1;
                  end
               end else begin
                  note_d = notes_in[{sel_q, 2'b00} +: 4];
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         tick_q   <= 16'd0;
         period_q <= P_DEF;
         beat_q   <= 3'd0;
         strobe_q <= 1'b0;
         sel_q    <= 3'd0;
         toggle_q <= 8'h00;
         note_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         beat_q   <= beat_d;
         strobe_q <= strobe_d;
         sel_q    <= sel_d;
         toggle_q <= toggle_d;
         note_q   <= note_d;
      end
   end

   assign beat        = {1'b0, beat_q};
   assign beat_strobe = strobe_q;
   assign sel_step    = sel_q;
   assign toggle_out  = toggle_q;
   assign note_out    = note_q;
   assign running     = (state_q == RUNNING);

endmodule

// File: tb/tb_sequencer_scheduler.sv
// Directed bench for sequencer_scheduler: a per-cycle vector table for the main
// flow plus hand-written sequences for tempo limits, reset and step editing.
module tb_sequencer_scheduler;

   typedef struct packed {
      logic       seqOn;
      logic       playPause;
      logic       tempoUp;
      logic       tempoDown;
      logic       stepNext;
      logic       toggleIn;
      logic [3:0] expBeat;
      logic       expStrobe;
      logic [2:0] expSel;
      logic [7:0] expToggle;
      logic [3:0] expNote;
      logic       expRunning;
   } vec_t;

   logic        clk;
   logic        n_rst;
   logic        sequencerOn, playPause, tempoUp, tempoDown, stepNext, toggleIn;
   logic [31:0] notesIn;
   logic [3:0]  beat;
   logic        beatStrobe;
   logic [2:0]  selStep;
   logic [7:0]  toggleOut;
   logic [3:0]  noteOut;
   logic        running;

   int total;
   int bad;
   int gap;
   int noteOf[8];
   vec_t vecs[30];

   sequencer_scheduler #(
      .PERIOD_DEFAULT(4),
      .PERIOD_MIN(2),
      .PERIOD_MAX(6),
      .PERIOD_STEP(1)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .sequencer_on(sequencerOn),
      .play_pause(playPause),
      .tempo_up(tempoUp),
      .tempo_down(tempoDown),
      .step_next(stepNext),
      .toggle_in(toggleIn),
      .notes_in(notesIn),
      .beat(beat),
      .beat_strobe(beatStrobe),
      .sel_step(selStep),
      .toggle_out(toggleOut),
      .note_out(noteOut),
      .running(running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t makeVec(input logic s, input logic pp, input logic up, input logic dn,
                                    input logic sn, input logic ti, input logic [3:0] b,
                                    input logic st, input logic [2:0] sel, input logic [7:0] tog,
                                    input logic [3:0] nt, input logic run);
      vec_t v;
      v.seqOn = s; v.playPause = pp; v.tempoUp = up; v.tempoDown = dn;
      v.stepNext = sn; v.toggleIn = ti; v.expBeat = b; v.expStrobe = st;
      v.expSel = sel; v.expToggle = tog; v.expNote = nt; v.expRunning = run;
      return v;
   endfunction

   // Drive one cycle of inputs, let a rising edge pass, and return 1 time unit later.
   task automatic applyStimulus(input logic s, input logic pp, input logic up, input logic dn,
                                input logic sn, input logic ti);
      sequencerOn = s; playPause = pp; tempoUp = up; tempoDown = dn;
      stepNext = sn; toggleIn = ti;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " beat"}, int'(beat), 0);
      checkOutput({tag, " strobe"}, int'(beatStrobe), 0);
      checkOutput({tag, " sel"}, int'(selStep), 0);
      checkOutput({tag, " toggle"}, int'(toggleOut), 0);
      checkOutput({tag, " note"}, int'(noteOut), 0);
      checkOutput({tag, " running"}, int'(running), 0);
   endtask

   // Cycles between two consecutive strobes; -1 when a strobe never shows up.
   task automatic measureGap(output int g);
      int n;
      n = 0;
      do begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         n++;
      end while (!beatStrobe && n < 50);
      if (!beatStrobe) begin
         g = -1;
         return;
      end
      n = 0;
      do begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         n++;
      end while (!beatStrobe && n < 50);
      g = beatStrobe ? n : -1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      noteOf = '{1, 7, 8, 9, 10, 11, 12, 13};
      notesIn = 32'hDCBA_9871;
      n_rst = 1'b0;
      sequencerOn = 0; playPause = 0; tempoUp = 0; tempoDown = 0; stepNext = 0; toggleIn = 0;

      applyStimulus(0, 0, 0, 0, 0, 0);
      checkAllZero("reset");
      n_rst = 1'b1;

      //                 seq pp up dn sn ti  beat st sel tog    note run
      vecs[0]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0,  0);
      vecs[1]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 1,  0);
      vecs[2]  = makeVec(1, 0, 0, 0, 1, 0,  0, 0, 1, 8'h00, 1,  0);
      vecs[3]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 1, 8'h00, 7,  0);
      vecs[4]  = makeVec(1, 0, 0, 0, 0, 1,  0, 0, 1, 8'h02, 7,  0);
      vecs[5]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 1, 8'h00, 7,  0);
      vecs[6]  = makeVec(1, 0, 0, 0, 1, 1,  0, 0, 2, 8'h02, 7,  0);
      vecs[7]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 2, 8'h00, 8,  0);
      vecs[8]  = makeVec(1, 1, 0, 0, 0, 0,  0, 0, 2, 8'h00, 8,  1);
      vecs[9]  = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 2, 8'h00, 1,  1);
      vecs[10] = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 2, 8'h00, 1,  1);
      vecs[11] = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 2, 8'h00, 1,  1);
      vecs[12] = makeVec(1, 0, 0, 0, 0, 0,  1, 1, 2, 8'h00, 1,  1);
      vecs[13] = makeVec(1, 0, 0, 0, 0, 0,  1, 0, 2, 8'h00, 7,  1);
      vecs[14] = makeVec(1, 0, 1, 0, 0, 0,  1, 0, 2, 8'h00, 7,  1);
      vecs[15] = makeVec(1, 0, 0, 0, 0, 0,  2, 1, 2, 8'h00, 7,  1);
      vecs[16] = makeVec(1, 0, 0, 0, 0, 0,  2, 0, 2, 8'h00, 8,  1);
      vecs[17] = makeVec(1, 0, 0, 0, 0, 0,  2, 0, 2, 8'h00, 8,  1);
      vecs[18] = makeVec(1, 0, 0, 0, 0, 0,  3, 1, 2, 8'h00, 8,  1);
      vecs[19] = makeVec(1, 1, 0, 0, 0, 0,  3, 0, 2, 8'h00, 9,  0);
      vecs[20] = makeVec(1, 0, 0, 0, 0, 0,  3, 0, 2, 8'h00, 8,  0);
      vecs[21] = makeVec(1, 1, 0, 0, 0, 0,  3, 0, 2, 8'h00, 8,  1);
      vecs[22] = makeVec(1, 0, 0, 0, 0, 0,  3, 0, 2, 8'h00, 9,  1);
      vecs[23] = makeVec(1, 0, 0, 0, 0, 0,  4, 1, 2, 8'h00, 9,  1);
      vecs[24] = makeVec(0, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0,  0);
      vecs[25] = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0,  0);
      vecs[26] = makeVec(1, 1, 0, 0, 0, 0,  0, 0, 0, 8'h00, 1,  1);
      vecs[27] = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 1,  1);
      vecs[28] = makeVec(1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00, 1,  1);
      vecs[29] = makeVec(1, 0, 0, 0, 0, 0,  1, 1, 0, 8'h00, 1,  1);

      for (int i = 0; i < 30; i++) begin
         applyStimulus(vecs[i].seqOn, vecs[i].playPause, vecs[i].tempoUp,
                       vecs[i].tempoDown, vecs[i].stepNext, vecs[i].toggleIn);
         checkOutput($sformatf("vec%0d beat", i), int'(beat), int'(vecs[i].expBeat));
         checkOutput($sformatf("vec%0d strobe", i), int'(beatStrobe), int'(vecs[i].expStrobe));
         checkOutput($sformatf("vec%0d sel", i), int'(selStep), int'(vecs[i].expSel));
         checkOutput($sformatf("vec%0d toggle", i), int'(toggleOut), int'(vecs[i].expToggle));
         checkOutput($sformatf("vec%0d note", i), int'(noteOut), int'(vecs[i].expNote));
         checkOutput($sformatf("vec%0d running", i), int'(running), int'(vecs[i].expRunning));
      end

      // Tempo limits: period 3 -> min 2, then up to max 6, then 5 held through up+down.
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
      measureGap(gap);
      checkOutput("gap at min", gap, 2);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, 0);
      measureGap(gap);
      checkOutput("gap at max", gap, 6);
      applyStimulus(1, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 0);
      measureGap(gap);
      checkOutput("gap up+down", gap, 5);

      // Shrinking the period below the current tick fires the beat immediately.
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("shrink idle strobe", int'(beatStrobe), 0);
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("shrink a strobe", int'(beatStrobe), 0);
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("shrink b strobe", int'(beatStrobe), 0);
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("shrink c strobe", int'(beatStrobe), 1);

      // Reset while running with a toggle request in the same cycle.
      n_rst = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 1);
      n_rst = 1'b1;
      checkAllZero("midrun reset");

      // Free run at the default period with a reset glitch between edges.
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("run start running", int'(running), 1);
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin
            #1 n_rst = 1'b0;
            #2 n_rst = 1'b1;
         end
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("run%0d strobe", k), int'(beatStrobe), (k % 4 == 0) ? 1 : 0);
         checkOutput($sformatf("run%0d beat", k), int'(beat), (k / 4) % 8);
         checkOutput($sformatf("run%0d note", k), int'(noteOut), noteOf[((k - 1) / 4) % 8]);
      end
      checkOutput("run end running", int'(running), 1);

      // Reset after lengthening the period must restore the default period.
      applyStimulus(1, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0);
      n_rst = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      n_rst = 1'b1;
      checkAllZero("slow reset");
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      measureGap(gap);
      checkOutput("gap after reset", gap, 4);
      checkOutput("beat before stop", int'(beat), 2);

      // Stop, then edit steps while the beat stays frozen.
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("stop running", int'(running), 0);
      for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 1, 0);
      checkOutput("step x9 sel", int'(selStep), 1);
      checkOutput("frozen beat", int'(beat), 2);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("toggle step1", int'(toggleOut), 8'h02);
      checkOutput("preview step1", int'(noteOut), 7);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("toggle clears", int'(toggleOut), 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 1, 0);
      checkOutput("sel at 7", int'(selStep), 7);
      applyStimulus(1, 0, 0, 0, 1, 1);
      checkOutput("toggle wrap", int'(toggleOut), 8'h80);
      checkOutput("sel wrap", int'(selStep), 0);
      checkOutput("preview step7", int'(noteOut), 13);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("preview step0", int'(noteOut), 1);
      checkOutput("toggle after wrap", int'(toggleOut), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
